// File: rtl/cost_func_unit.sv
// Squared-error cost (target - sigmoid(x))^2 in Q6.11 for the LSTM output stage.
// Optional macro COST_ACCUM_EN: averages the cost over SEQ_LEN samples and strobes once per sequence.
module cost_func_unit #(
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int BITWIDTH = QN + QM + 1,
    parameter int SEQ_LEN  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] dataIn,
    input  logic                dataValid,
    input  logic                target,
    input  logic                seqClear,
    output logic [BITWIDTH-1:0] costFunc,
    output logic                newCostFunc,
    output logic                busy,
    output logic                overrun
);
    localparam int BW = BITWIDTH;
    localparam int PW = 2 * BITWIDTH;

    localparam logic [BW:0]   A_SAT    = (BW+1)'(10240);
    localparam logic [BW:0]   A_HI     = (BW+1)'(4864);
    localparam logic [BW:0]   A_MID    = (BW+1)'(2048);
    localparam logic [BW-1:0] ONE      = BW'(2048);
    localparam logic [PW-1:0] RND_HALF = {{(PW-QM){1'b0}}, 1'b1, {(QM-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SIG, DIFF, SQR, RND} state_t;

    state_t        state_q;
    logic          valid_q;
    logic [BW-1:0] x_q;
    logic          tgt_q;
    logic [BW-1:0] y_q;
    logic [BW-1:0] diff_q;
    logic [PW-1:0] prod_q;
    logic [BW-1:0] cost_q;
    logic          strobe_q;
    logic          overrun_q;

    logic          trigger_d;
    logic [BW:0]   abs_x_d;
    logic [BW-1:0] mag_d;
    logic [BW-1:0] seg_d;
    logic [BW-1:0] y_d;
    logic [BW-1:0] diff_d;
    logic [PW-1:0] diff_ext_d;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] rnd_d;
    logic [BW-1:0] cost_d;

    assign trigger_d = dataValid & ~valid_q;

    // |x| is one bit wider so the most negative input cannot wrap.
    always_comb begin
        abs_x_d = x_q[BW-1] ? ((BW+1)'(0) - {x_q[BW-1], x_q}) : {x_q[BW-1], x_q};
        mag_d   = abs_x_d[BW-1:0];
        if (abs_x_d >= A_SAT) begin
            seg_d = ONE;
        end else if (abs_x_d >= A_HI) begin
            seg_d = (mag_d >> 5) + BW'(1728);
        end else if (abs_x_d >= A_MID) begin
            seg_d = (mag_d >> 3) + BW'(1280);
        end else begin
            seg_d = (mag_d >> 2) + BW'(1024);
        end
        y_d = x_q[BW-1] ? (ONE - seg_d) : seg_d;
    end

    always_comb begin
        diff_d     = (tgt_q ? ONE : '0) - y_q;
        diff_ext_d = {{BW{diff_q[BW-1]}}, diff_q};
        prod_d     = diff_ext_d * diff_ext_d;
        rnd_d      = (prod_q + RND_HALF) >> QM;
        cost_d     = (|rnd_d[PW-1:BW]) ? '1 : rnd_d[BW-1:0];
    end

`ifdef COST_ACCUM_EN
    localparam int LG = $clog2(SEQ_LEN);
    localparam int AW = BW + LG;
    localparam logic [AW-1:0] AVG_HALF = AW'(SEQ_LEN / 2);

    logic [AW-1:0] acc_q;
    logic [LG-1:0] cnt_q;
    logic [AW-1:0] acc_sum_d;
    logic [AW-1:0] avg_d;
    logic [BW-1:0] avg_cost_d;

    always_comb begin
        acc_sum_d  = acc_q + AW'(cost_d);
        avg_d      = (acc_sum_d + AVG_HALF) >> LG;
        avg_cost_d = (|avg_d[AW-1:BW]) ? '1 : avg_d[BW-1:0];
    end
`else
    logic unused_cfg;
    assign unused_cfg = seqClear ^ SEQ_LEN[0];
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            x_q       <= '0;
            tgt_q     <= 1'b0;
            y_q       <= '0;
            diff_q    <= '0;
            prod_q    <= '0;
            cost_q    <= '0;
            strobe_q  <= 1'b0;
            overrun_q <= 1'b0;
`ifdef COST_ACCUM_EN
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            valid_q  <= dataValid;
            strobe_q <= 1'b0;
            if (trigger_d && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (trigger_d) begin
                        x_q     <= dataIn;
                        tgt_q   <= target;
                        state_q <= SIG;
                    end
                end
                SIG: begin
                    y_q     <= y_d;
                    state_q <= DIFF;
                end
                DIFF: begin
                    diff_q  <= diff_d;
                    state_q <= SQR;
                end
                SQR: begin
                    prod_q  <= prod_d;
                    state_q <= RND;
                end
                RND: begin
                    state_q <= IDLE;
`ifdef COST_ACCUM_EN
                    if (!seqClear) begin
                        if (cnt_q == LG'(SEQ_LEN - 1)) begin
                            cost_q   <= avg_cost_d;
                            strobe_q <= 1'b1;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            acc_q <= acc_sum_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`else
                    cost_q   <= cost_d;
                    strobe_q <= 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
`ifdef COST_ACCUM_EN
            // A clear landing with an accumulate discards that sample.
            if (seqClear) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
`endif
        end
    end

    assign costFunc    = cost_q;
    assign newCostFunc = strobe_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_cost_func_unit.sv
// Testbench for cost_func_unit: directed and random samples against a plain-arithmetic reference model.
module tb_cost_func_unit;
    localparam int BW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] data_in;
    logic          data_valid;
    logic          tgt;
    logic          seq_clear;
    logic [BW-1:0] cost;
    logic          new_cost;
    logic          busy;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cost_func_unit dut (
        .clock      (clk),
        .reset      (rst_n),
        .dataIn     (data_in),
        .dataValid  (data_valid),
        .target     (tgt),
        .seqClear   (seq_clear),
        .costFunc   (cost),
        .newCostFunc(new_cost),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Reference: sigmoid approximation, error and rounded square in integer Q.11 arithmetic.
    function automatic int model_cost(input int x, input int t);
        int a, y, d, c;
        a = (x < 0) ? -x : x;
        if (a >= 10240)     y = 2048;
        else if (a >= 4864) y = a / 32 + 1728;
        else if (a >= 2048) y = a / 8 + 1280;
        else                y = a / 4 + 1024;
        if (x < 0) y = 2048 - y;
        d = (t != 0 ? 2048 : 0) - y;
        c = (d * d + 1024) / 2048;
        if (c > 262143) c = 262143;
        return c;
    endfunction

    function automatic int rand_x();
        logic [17:0] r;
        int th[6] = '{2047, 2048, 4863, 4864, 10239, 10240};
        int x;
        case ($urandom_range(0, 2))
            0: x = int'($urandom_range(0, 24000)) - 12000;
            1: begin
                r = 18'($urandom);
                x = int'($signed(r));
            end
            default: begin
                x = th[$urandom_range(0, 5)];
                if ($urandom_range(0, 1) == 1) x = -x;
            end
        endcase
        return x;
    endfunction

    // Called at a falling edge: one rising edge of dataValid, then observes 12 cycles.
    task automatic run_sample(input int x, input int t, output logic [BW-1:0] got,
                              output int lat, output int busy_cnt, output int strobes);
        data_in    = 18'(x);
        tgt        = t[0];
        data_valid = 1'b1;
        got = '0; lat = -1; busy_cnt = 0; strobes = 0;
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (busy) busy_cnt++;
            if (new_cost) begin
                strobes++;
                if (lat < 0) begin
                    lat = i;
                    got = cost;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_valid = 1'b0; tgt = 1'b0; seq_clear = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (cost !== 18'd0) begin failures++; $display("FAIL reset_cost: got %0d expected 0", cost); end
        checks++; if (new_cost !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %0b expected 0", new_cost); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: cost=%0d busy=%0b overrun=%0b", cost, busy, overrun);
    endtask

    task automatic test_directed();
        int dx[6] = '{0, 10240, 10240, -131072, -2048, 4096};
        int dt[6] = '{1, 1, 0, 0, 0, 1};
        int de[6] = '{512, 0, 2048, 0, 128, 32};
        logic [BW-1:0] got;
        int lat, bc, st;
        for (int i = 0; i < 6; i++) begin
            run_sample(dx[i], dt[i], got, lat, bc, st);
            $display("directed x=%0d t=%0d cost=%0d lat=%0d busy=%0d strobes=%0d", dx[i], dt[i], got, lat, bc, st);
            checks++; if (got !== 18'(de[i])) begin failures++; $display("FAIL directed_cost[%0d]: got %0d expected %0d", i, got, de[i]); end
            checks++; if (lat != 5) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected 5", i, lat); end
            checks++; if (st != 1) begin failures++; $display("FAIL directed_strobes[%0d]: got %0d expected 1", i, st); end
            checks++; if (bc != 4) begin failures++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected 4", i, bc); end
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] got;
        int lat, bc, st, x, t, exp;
        for (int i = 0; i < 40; i++) begin
            x = rand_x();
            t = int'($urandom_range(0, 1));
            exp = model_cost(x, t);
            run_sample(x, t, got, lat, bc, st);
            $display("random x=%0d t=%0d cost=%0d expected=%0d lat=%0d", x, t, got, exp, lat);
            checks++; if (got !== 18'(exp)) begin failures++; $display("FAIL random_cost: x=%0d t=%0d got %0d expected %0d", x, t, got, exp); end
            checks++; if (lat != 5 || st != 1) begin failures++; $display("FAIL random_timing: got lat=%0d strobes=%0d expected lat=5 strobes=1", lat, st); end
        end
    endtask

    task automatic test_level_hold();
        int st = 0;
        int exp = model_cost(4096, 1);
        logic [BW-1:0] got = '0;
        data_in = 18'(4096); tgt = 1'b1; data_valid = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 20) data_valid = 1'b0;
            if (new_cost) begin
                st++;
                got = cost;
            end
        end
        $display("level_hold strobes=%0d cost=%0d", st, got);
        checks++; if (st != 1) begin failures++; $display("FAIL level_hold_strobes: got %0d expected 1", st); end
        checks++; if (got !== 18'(exp)) begin failures++; $display("FAIL level_hold_cost: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_back_to_back();
        int x1 = rand_x();
        int x2 = rand_x();
        int t1 = int'($urandom_range(0, 1));
        int t2 = int'($urandom_range(0, 1));
        int e1 = model_cost(x1, t1);
        int e2 = model_cost(x2, t2);
        data_in = 18'(x1); tgt = t1[0]; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("back_to_back first strobe=%0b cost=%0d expected=%0d", new_cost, cost, e1);
        checks++; if (new_cost !== 1'b1 || cost !== 18'(e1)) begin failures++; $display("FAIL b2b_first: got strobe=%0b cost=%0d expected strobe=1 cost=%0d", new_cost, cost, e1); end
        data_in = 18'(x2); tgt = t2[0]; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy=%0b expected 1", busy); end
        repeat (4) @(negedge clk);
        $display("back_to_back second strobe=%0b cost=%0d expected=%0d", new_cost, cost, e2);
        checks++; if (new_cost !== 1'b1 || cost !== 18'(e2)) begin failures++; $display("FAIL b2b_second: got strobe=%0b cost=%0d expected strobe=1 cost=%0d", new_cost, cost, e2); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %0b expected 0", overrun); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun();
        int st = 0;
        int at = -1;
        logic [BW-1:0] got = '0;
        data_in = 18'(-2048); tgt = 1'b0; data_valid = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (new_cost) begin
                st++;
                at = i;
                got = cost;
            end
            if (i == 1) data_valid = 1'b0;
            if (i == 2) begin data_in = '0; tgt = 1'b1; data_valid = 1'b1; end
            if (i == 3) data_valid = 1'b0;
        end
        $display("overrun strobes=%0d at=%0d cost=%0d overrun=%0b", st, at, got, overrun);
        checks++; if (st != 1 || at != 5) begin failures++; $display("FAIL overrun_strobe: got %0d strobes at %0d expected 1 at 5", st, at); end
        checks++; if (got !== 18'd128) begin failures++; $display("FAIL overrun_cost: got %0d expected 128", got); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag: got %0b expected 1", overrun); end
    endtask

    task automatic test_reset_abort();
        logic [BW-1:0] got;
        int lat, bc, st;
        data_in = '0; tgt = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset_abort strobe=%0b cost=%0d busy=%0b overrun=%0b", new_cost, cost, busy, overrun);
        checks++; if (new_cost !== 1'b0 || cost !== 18'd0) begin failures++; $display("FAIL abort_output: got strobe=%0b cost=%0d expected 0/0", new_cost, cost); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%0b overrun=%0b expected 0/0", busy, overrun); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (new_cost !== 1'b0) begin failures++; $display("FAIL abort_stale_strobe: got %0b expected 0", new_cost); end
        run_sample(0, 1, got, lat, bc, st);
        $display("after_release cost=%0d lat=%0d", got, lat);
        checks++; if (got !== 18'd512 || lat != 5) begin failures++; $display("FAIL after_release: got cost=%0d lat=%0d expected 512/5", got, lat); end
    endtask

`ifdef COST_ACCUM_EN
    task automatic run_sequence(input string tag, input bit all_zero_one, input logic [BW-1:0] prev);
        logic [BW-1:0] got;
        int lat, bc, st, x, t, sum, exp;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            x = all_zero_one ? 0 : rand_x();
            t = all_zero_one ? 1 : int'($urandom_range(0, 1));
            sum += model_cost(x, t);
            run_sample(x, t, got, lat, bc, st);
            if (i < 7) begin
                checks++; if (st != 0 || cost !== prev) begin failures++; $display("FAIL %s_hold[%0d]: got strobes=%0d cost=%0d expected 0/%0d", tag, i, st, cost, prev); end
            end else begin
                exp = (sum + 4) / 8;
                $display("%s avg cost=%0d expected=%0d lat=%0d", tag, got, exp, lat);
                checks++; if (st != 1 || lat != 5 || got !== 18'(exp)) begin failures++; $display("FAIL %s_avg: got strobes=%0d lat=%0d cost=%0d expected 1/5/%0d", tag, st, lat, got, exp); end
            end
        end
    endtask

    task automatic test_accum();
        logic [BW-1:0] got;
        int lat, bc, st;
        run_sequence("accum_const", 1'b1, '0);
        run_sequence("accum_rand", 1'b0, 18'd512);
        for (int i = 0; i < 3; i++) begin
            run_sample(rand_x(), 1, got, lat, bc, st);
            checks++; if (st != 0) begin failures++; $display("FAIL accum_preclear[%0d]: got %0d strobes expected 0", i, st); end
        end
        seq_clear = 1'b1;
        @(negedge clk);
        seq_clear = 1'b0;
        run_sequence("accum_cleared", 1'b0, cost);
    endtask
`endif

    initial begin
        test_reset();
`ifdef COST_ACCUM_EN
        test_accum();
`else
        test_directed();
        test_random();
        test_level_hold();
        test_back_to_back();
        test_overrun();
        test_reset_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cost_func_unit.md
Name: cost_func_unit

Overview:
- Hardware replacement for the behavioural cost computation after the output perceptron in the LSTM training loop.
- Consumes the perceptron output (networkOutput) and its completion flag (dataReadyP), plus the 1-bit target label.
- Computes squared error (target - sigmoid(y))^2 in fixed point.
- Presents the result to network as costFunc, with a one-cycle newCostFunc strobe, so the training path needs no real-valued bench code.

Parameters:
- QN, 6, integer bits of the fixed-point format.
- QM, 11, fractional bits.
- BITWIDTH, QN+QM+1, derived data width (18); not to be overridden.
- SEQ_LEN, 8, samples per sequence; power of 2, >= 2; used only with COST_ACCUM_EN.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- dataIn  in  BITWIDTH  signed Q6.11 perceptron output (networkOutput).
- dataValid  in  1  perceptron completion flag (dataReadyP); a rising edge triggers one computation.
- target  in  1  expected label (modelOutput); 0 maps to 0.0, 1 maps to 1.0.
- seqClear  in  1  clears sample counter and accumulator; ignored unless COST_ACCUM_EN.
- costFunc  out  BITWIDTH  unsigned Q6.11 cost, range 0..2048.
- newCostFunc  out  1  one-cycle strobe: costFunc updated.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky: a trigger arrived while busy.

Behaviour:
- Reset (reset==0 at a clock edge): FSM to IDLE; costFunc=0, newCostFunc=0, busy=0, overrun=0; edge-detect register cleared; accumulator and counter cleared. Reset mid-computation aborts it with no strobe.
- Trigger:
  - dataValid is registered; trigger = dataValid & !dataValid_q.
  - A level held high for any number of cycles yields exactly one trigger.
  - In IDLE, a trigger captures dataIn and target at that edge (cycle 0).
- FSM: IDLE -> SIG (c1) -> DIFF (c2) -> SQR (c3) -> RND (c4) -> IDLE. newCostFunc=1 during c5 only; costFunc is valid from c5 and held until the next update. Latency is 5 cycles from the capture edge to the strobe. busy is high c1..c4.
- SIG: piecewise-linear sigmoid on a = |x|, shift-and-add only, result y in Q.11:
  - a >= 10240 (5.0): y = 2048.
  - 4864 <= a < 10240: y = (a>>5) + 1728.
  - 2048 <= a < 4864: y = (a>>3) + 1280.
  - a < 2048: y = (a>>2) + 1024.
  - x negative: y = 2048 - y.
  - |x| is computed in BITWIDTH+1 bits so that x = -2^17 cannot overflow.
- DIFF: d = (target ? 2048 : 0) - y, signed BITWIDTH; |d| <= 2048.
- SQR: p = d*d, 2*BITWIDTH bits, Q.22; maps to one DSP multiply.
- RND: c = (p + 2^(QM-1)) >> QM. Saturate c at 2^BITWIDTH-1; this is unreachable given the range, but the saturation logic is required.
- Simultaneous events:
  - A trigger while busy is dropped and sets overrun.
  - A trigger in the same cycle as newCostFunc (FSM back in IDLE) is accepted.
  - reset takes priority over everything.

Optional Feature:
- Macro: COST_ACCUM_EN.
- Without the macro: one cost and one strobe per trigger, as above. seqClear is unused.
- With the macro, per-sample cost c is added to an accumulator of BITWIDTH+log2(SEQ_LEN) bits and a sample counter increments:
  - Only when the counter wraps from SEQ_LEN-1 to 0: costFunc = (acc + SEQ_LEN/2) >> log2(SEQ_LEN), newCostFunc pulses, and the accumulator is cleared in the same cycle.
  - On other samples: no strobe, and costFunc holds its previous value.
  - seqClear=1 clears accumulator and counter on that edge. It has priority over an accumulate landing on the same edge; that sample is discarded.
  - Total latency is unchanged: the strobe falls on c5 of the SEQ_LEN-th sample.

Test Plan:
- dataIn=0, target=1, single dataValid edge -> costFunc=512 (0.25), newCostFunc high exactly 5 cycles after the capture edge for 1 cycle; busy high for 4 cycles.
- dataIn=10240 (5.0): target=1 -> costFunc=0; target=0 -> costFunc=2048. dataIn=-131072, target=0 -> costFunc=0 with no overflow.
- dataIn=-2048 (-1.0), target=0 -> y=512, d=-512, costFunc=128. dataIn=4096 (2.0), target=1 -> y=1792, costFunc=32.
- dataValid held high 20 cycles -> one strobe. Second rising edge 2 cycles after the first -> dropped, overrun=1 until reset, one strobe with the first sample's result.
- reset driven low at c3 of a computation -> no strobe; costFunc=0, busy=0, overrun=0 on the next cycle. A trigger on the cycle after reset release is processed normally.
- With COST_ACCUM_EN and SEQ_LEN=8: 8 samples of (0,1), each c=512 -> a single strobe after the 8th, costFunc=512. seqClear pulsed after 3 samples -> the next strobe comes only after 8 further samples.
